// File: rtl/palette_rgb_encoder_if.sv
// Pixel-in / index-out stream bundle for the palette encoder.
// The master side is the pixel source plus the result consumer.
interface palette_rgb_encoder_if #(
  parameter int IW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   in_rgb;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [5:0]    out_dist;
  logic          out_exact;

  modport master (
    output in_valid,
    output in_rgb,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_dist,
    input  out_exact
  );

  modport slave (
    input  in_valid,
    input  in_rgb,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_dist,
    output out_exact
  );
endinterface

// File: rtl/palette_rgb_encoder.sv
// Nearest-colour search: RGB444 pixel -> 4-bit palette index.
// One palette entry is compared per clock; the palette is run-time writable.
module palette_rgb_encoder #(
  parameter int N_ENTRIES  = 16,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW = $clog2(N_ENTRIES)
) (
  input  logic          Clk,
  input  logic          Reset,
  palette_rgb_encoder_if.slave bus,
  input  logic          pal_we,
  input  logic [IW-1:0] pal_waddr,
  input  logic [11:0]   pal_wdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  function automatic logic [11:0] pal_default(input int i);
    logic [11:0] c;
    case (i)
      0:       c = 12'h1D6;
      1:       c = 12'hF0F;
      2:       c = 12'hCED;
      3:       c = 12'hE43;
      4:       c = 12'h2C7;
      5:       c = 12'hE5F;
      6:       c = 12'hFFF;
      7:       c = 12'h878;
      8:       c = 12'h8EA;
      9:       c = 12'h595;
      10:      c = 12'h4D8;
      11:      c = 12'h2B6;
      12:      c = 12'h3D7;
      13:      c = 12'hCBC;
      14:      c = 12'h4A8;
      15:      c = 12'h1C6;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] chan_abs(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] d;
    logic [4:0] m;
    d = {1'b0, a} - {1'b0, b};
    m = d[4] ? (5'd0 - d) : d;
    return m[3:0];
  endfunction

  // Manhattan distance; 3 x 15 = 45 fits in 6 bits
  function automatic logic [5:0] rgb_dist(
    input logic [11:0] a,
    input logic [11:0] b
  );
    logic [3:0] dr;
    logic [3:0] dg;
    logic [3:0] db;
    dr = chan_abs(a[11:8], b[11:8]);
    dg = chan_abs(a[7:4], b[7:4]);
    db = chan_abs(a[3:0], b[3:0]);
    return {2'b00, dr} + {2'b00, dg} + {2'b00, db};
  endfunction

  logic [11:0]   pal_q [N_ENTRIES];

  state_e        state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [5:0]    bdist_q, bdist_d;
  logic [IW-1:0] bidx_q, bidx_d;
  logic [IW-1:0] res_idx_q, res_idx_d;
  logic [5:0]    res_dist_q, res_dist_d;
  logic          res_exact_q, res_exact_d;

  logic [11:0]   cur_entry;
  logic [5:0]    d_now;
  logic          better;
  logic          last;
  logic [5:0]    nb_dist;
  logic [IW-1:0] nb_idx;

  // Scan reads the registered entry, so a same-cycle write is not seen
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else if (pal_we && (int'(pal_waddr) < N_ENTRIES)) begin
      pal_q[pal_waddr] <= pal_wdata;
    end
  end

  assign cur_entry = pal_q[k_q];
  assign d_now     = rgb_dist(rgb_q, cur_entry);
  assign better    = d_now < bdist_q;
  assign nb_dist   = better ? d_now : bdist_q;
  assign nb_idx    = better ? k_q : bidx_q;
  assign last      = (k_q == IW'(N_ENTRIES - 1)) ||
                     (EARLY_EXIT && (d_now == 6'd0));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      rgb_q       <= '0;
      bdist_q     <= '0;
      bidx_q      <= '0;
      res_idx_q   <= '0;
      res_dist_q  <= '0;
      res_exact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rgb_q       <= rgb_d;
      bdist_q     <= bdist_d;
      bidx_q      <= bidx_d;
      res_idx_q   <= res_idx_d;
      res_dist_q  <= res_dist_d;
      res_exact_q <= res_exact_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rgb_d       = rgb_q;
    bdist_d     = bdist_q;
    bidx_d      = bidx_q;
    res_idx_d   = res_idx_q;
    res_dist_d  = res_dist_q;
    res_exact_d = res_exact_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          rgb_d   = bus.in_rgb;
          k_d     = '0;
          bdist_d = 6'd63;
          bidx_d  = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        bdist_d = nb_dist;
        bidx_d  = nb_idx;
        if (last) begin
          res_idx_d   = nb_idx;
          res_dist_d  = nb_dist;
          res_exact_d = (nb_dist == 6'd0);
          state_d     = S_DONE;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_index = res_idx_q;
  assign bus.out_dist  = res_dist_q;
  assign bus.out_exact = res_exact_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_palette_rgb_encoder.sv
// Directed checks for palette_rgb_encoder: latency, ties,
// palette writes during a scan, hold, reset mid-search, full scan.
module tb_palette_rgb_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        busy;
  logic        pal_we_b;
  logic [3:0]  pal_waddr_b;
  logic [11:0] pal_wdata_b;
  logic        busy_b;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  palette_rgb_encoder_if #(.IW(4)) ifa ();
  palette_rgb_encoder_if #(.IW(4)) ifb ();

  palette_rgb_encoder #(
    .N_ENTRIES (16),
    .EARLY_EXIT(1'b1)
  ) dut_a (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (ifa),
    .pal_we   (pal_we),
    .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata),
    .busy     (busy)
  );

  palette_rgb_encoder #(
    .N_ENTRIES (16),
    .EARLY_EXIT(1'b0)
  ) dut_b (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (ifb),
    .pal_we   (pal_we_b),
    .pal_waddr(pal_waddr_b),
    .pal_wdata(pal_wdata_b),
    .busy     (busy_b)
  );

  task automatic start_a(input logic [11:0] rgb);
    @(negedge Clk);
    ifa.in_valid = 1'b1;
    ifa.in_rgb   = rgb;
    @(posedge Clk);
    @(negedge Clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_a(input int start, output int cyc);
    cyc = start;
    while (!ifa.out_valid && cyc < 40) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic pop_a();
    ifa.out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ifa.out_ready = 1'b0;
  endtask

  task automatic check_res(
    input string nm,
    input int cyc, input int want_cyc,
    input logic [3:0] want_idx,
    input logic [5:0] want_dist,
    input logic want_exact
  );
    total++;
    if (cyc !== want_cyc) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, cyc, want_cyc);
    end
    total++;
    if (ifa.out_index !== want_idx) begin
      bad++;
      $display("FAIL %s_index got=%0d want=%0d", nm, ifa.out_index, want_idx);
    end
    total++;
    if (ifa.out_dist !== want_dist) begin
      bad++;
      $display("FAIL %s_dist got=%0d want=%0d", nm, ifa.out_dist, want_dist);
    end
    total++;
    if (ifa.out_exact !== want_exact) begin
      bad++;
      $display("FAIL %s_exact got=%0b want=%0b", nm, ifa.out_exact, want_exact);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({ifa.out_valid, ifa.in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=010",
               {ifa.out_valid, ifa.in_ready, busy});
    end
    total++;
    if ({ifa.out_index, ifa.out_dist, ifa.out_exact} !== 11'd0) begin
      bad++;
      $display("FAIL reset_out got=%h want=0",
               {ifa.out_index, ifa.out_dist, ifa.out_exact});
    end
    Reset = 1'b0;
  endtask

  task automatic test_exact_white();
    int cyc;
    start_a(12'hFFF);
    wait_a(0, cyc);
    check_res("t1", cyc, 7, 4'd6, 6'd0, 1'b1);
    pop_a();
    total++;
    if (ifa.in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_idle got=%b%b want=10", ifa.in_ready, busy);
    end
  endtask

  task automatic test_tie_black();
    int cyc;
    start_a(12'h000);
    wait_a(0, cyc);
    check_res("t2", cyc, 16, 4'd9, 6'd19, 1'b0);
    pop_a();
  endtask

  task automatic test_pal_write();
    int cyc;
    @(negedge Clk);
    pal_we    = 1'b1;
    pal_waddr = 4'd2;
    pal_wdata = 12'h123;
    @(posedge Clk);
    @(negedge Clk);
    pal_we = 1'b0;
    start_a(12'h123);
    wait_a(0, cyc);
    check_res("t3", cyc, 3, 4'd2, 6'd0, 1'b1);
    pop_a();
  endtask

  task automatic test_hold();
    int cyc;
    start_a(12'hE43);
    wait_a(0, cyc);
    check_res("t4", cyc, 4, 4'd3, 6'd0, 1'b1);
    ifa.in_valid = 1'b1;
    ifa.in_rgb   = 12'h000;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      total++;
      if ({ifa.out_valid, ifa.in_ready, busy} !== 3'b101 ||
          ifa.out_index !== 4'd3 || ifa.out_dist !== 6'd0 ||
          ifa.out_exact !== 1'b1) begin
        bad++;
        $display("FAIL t4_hold%0d got=%b%b%b/%0d/%0d want=101/3/0",
                 i, ifa.out_valid, ifa.in_ready, busy,
                 ifa.out_index, ifa.out_dist);
      end
    end
    ifa.in_valid = 1'b0;
    pop_a();
    total++;
    if ({ifa.out_valid, ifa.in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL t4_release got=%b want=010",
               {ifa.out_valid, ifa.in_ready, busy});
    end
  endtask

  task automatic test_write_during_scan();
    int cyc;
    start_a(12'h000);
    pal_we    = 1'b1;
    pal_waddr = 4'd12;
    pal_wdata = 12'h001;
    @(posedge Clk);
    @(negedge Clk);
    pal_we = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    pal_we    = 1'b1;
    pal_waddr = 4'd5;
    pal_wdata = 12'h000;
    @(posedge Clk);
    @(negedge Clk);
    pal_waddr = 4'd3;
    @(posedge Clk);
    @(negedge Clk);
    pal_we = 1'b0;
    wait_a(7, cyc);
    check_res("tw", cyc, 16, 4'd12, 6'd1, 1'b0);
    pop_a();
  endtask

  task automatic test_reset_mid_search();
    int cyc;
    int seen;
    start_a(12'h000);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Reset     = 1'b1;
    pal_we    = 1'b1;
    pal_waddr = 4'd0;
    pal_wdata = 12'h000;
    @(posedge Clk);
    @(negedge Clk);
    Reset  = 1'b0;
    pal_we = 1'b0;
    total++;
    if ({ifa.out_valid, ifa.in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL t5_state got=%b want=010",
               {ifa.out_valid, ifa.in_ready, busy});
    end
    total++;
    if ({ifa.out_index, ifa.out_dist, ifa.out_exact} !== 11'd0) begin
      bad++;
      $display("FAIL t5_out got=%h want=0",
               {ifa.out_index, ifa.out_dist, ifa.out_exact});
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ifa.out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL t5_novalid got=%0d want=0", seen);
    end
    start_a(12'h123);
    wait_a(0, cyc);
    check_res("t5a", cyc, 16, 4'd9, 6'd13, 1'b0);
    pop_a();
    start_a(12'h000);
    wait_a(0, cyc);
    check_res("t5b", cyc, 16, 4'd9, 6'd19, 1'b0);
    pop_a();
  endtask

  task automatic test_full_scan();
    int cyc;
    start_a(12'h1D6);
    wait_a(0, cyc);
    check_res("t6a", cyc, 1, 4'd0, 6'd0, 1'b1);
    pop_a();
    @(negedge Clk);
    ifb.in_valid = 1'b1;
    ifb.in_rgb   = 12'h1D6;
    @(posedge Clk);
    @(negedge Clk);
    ifb.in_valid = 1'b0;
    cyc = 0;
    while (!ifb.out_valid && cyc < 40) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
    end
    total++;
    if (cyc !== 16) begin
      bad++;
      $display("FAIL t6_latency got=%0d want=16", cyc);
    end
    total++;
    if (ifb.out_index !== 4'd0 || ifb.out_dist !== 6'd0 ||
        ifb.out_exact !== 1'b1) begin
      bad++;
      $display("FAIL t6_result got=%0d/%0d/%0b want=0/0/1",
               ifb.out_index, ifb.out_dist, ifb.out_exact);
    end
    ifb.out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ifb.out_ready = 1'b0;
    total++;
    if (ifb.in_ready !== 1'b1 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL t6_idle got=%b%b want=10", ifb.in_ready, busy_b);
    end
  endtask

  initial begin
    Reset         = 1'b1;
    pal_we        = 1'b0;
    pal_waddr     = 4'd0;
    pal_wdata     = 12'h000;
    pal_we_b      = 1'b0;
    pal_waddr_b   = 4'd0;
    pal_wdata_b   = 12'h000;
    ifa.in_valid  = 1'b0;
    ifa.in_rgb    = 12'h000;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_rgb    = 12'h000;
    ifb.out_ready = 1'b0;
    test_reset();
    test_exact_white();
    test_tie_black();
    test_pal_write();
    test_hold();
    test_write_during_scan();
    test_reset_mid_search();
    test_full_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
